// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the AXI-Stream packet arbiter.
package axis_arb_pkg;

    localparam int unsigned MAX_N_IN  = 32;
    localparam int unsigned MAX_IDX_W = $clog2(MAX_N_IN);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int words_per_beat(input int bus_w, input int word_w);
        return bus_w / word_w;
    endfunction

    // First requester strictly after ptr, wrapping modulo n; returns ptr when nobody requests.
    function automatic int unsigned rr_next(input logic [MAX_N_IN-1:0] req,
                                            input int unsigned n,
                                            input int unsigned ptr);
        int unsigned idx;
        int unsigned result;
        logic found;
        result = ptr;
        found  = 1'b0;
        for (int unsigned i = 1; i <= MAX_N_IN; i++) begin
            idx = (ptr + i) % n;
            if (!found && (i <= n) && req[idx[MAX_IDX_W-1:0]]) begin
                result = idx;
                found  = 1'b1;
            end else begin
                found = found;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry register slice used as the optional output stage of the arbiter.
// Compiled only when AXIS_PACKET_ARBITER_OUT_REG_EN is defined.
`ifdef AXIS_PACKET_ARBITER_OUT_REG_EN
module axis_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         skid_valid_r;
    logic [W-1:0] skid_data_r;

    // Ready depends only on the skid register, so out_ready never reaches in_ready combinationally.
    assign in_ready = !skid_valid_r;

    // Output register with a spill slot for the beat that arrives while the output stalls.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid    <= 1'b0;
            out_data     <= '0;
            skid_valid_r <= 1'b0;
            skid_data_r  <= '0;
        end else if (in_valid && in_ready) begin
            if (out_valid && !out_ready) begin
                skid_data_r  <= in_data;
                skid_valid_r <= 1'b1;
            end else begin
                out_data  <= in_data;
                out_valid <= 1'b1;
            end
        end else if (out_ready || !out_valid) begin
            if (skid_valid_r) begin
                out_data     <= skid_data_r;
                out_valid    <= 1'b1;
                skid_valid_r <= 1'b0;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/axis_packet_arbiter.sv
// Packet-level round-robin arbiter sharing one AXI-Stream sink between N_IN sources.
// Define AXIS_PACKET_ARBITER_OUT_REG_EN to register all m_* outputs through a skid buffer.
module axis_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int N_IN           = 4,
    parameter int WORD_W         = 8,
    parameter int BUS_W          = 32,
    parameter int WORDS_PER_BEAT = words_per_beat(BUS_W, WORD_W)
) (
    input  logic                                           clk,
    input  logic                                           rstn,
    input  logic [N_IN-1:0]                                s_valid,
    output logic [N_IN-1:0]                                s_ready,
    input  logic [N_IN-1:0]                                s_last,
    input  logic [N_IN-1:0][WORDS_PER_BEAT-1:0]            s_keep,
    input  logic [N_IN-1:0][WORDS_PER_BEAT-1:0][WORD_W-1:0] s_data,
    output logic                                           m_valid,
    input  logic                                           m_ready,
    output logic                                           m_last,
    output logic [WORDS_PER_BEAT-1:0]                      m_keep,
    output logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]          m_data,
    output logic [$clog2(N_IN)-1:0]                        grant_idx,
    output logic                                           busy
);

    localparam int IDX_W = $clog2(N_IN);

    arb_state_t                              state_r;
    logic [IDX_W-1:0]                        ptr_r;
    logic [IDX_W-1:0]                        next_idx_s;
    logic                                    mux_valid_s;
    logic                                    mux_ready_s;
    logic                                    mux_last_s;
    logic [WORDS_PER_BEAT-1:0]               mux_keep_s;
    logic [WORDS_PER_BEAT-1:0][WORD_W-1:0]   mux_data_s;
    logic                                    fire_s;

    assign next_idx_s = IDX_W'(rr_next(MAX_N_IN'(s_valid), N_IN, 32'(ptr_r)));
    assign busy       = (state_r == BUSY);
    assign fire_s     = mux_valid_s && mux_ready_s;

    // Route the granted source; everything is zero while idle so nothing leaks between packets.
    always_comb begin
        mux_valid_s = 1'b0;
        mux_last_s  = 1'b0;
        mux_keep_s  = '0;
        mux_data_s  = '0;
        s_ready     = '0;
        if (state_r == BUSY) begin
            mux_valid_s          = s_valid[grant_idx];
            mux_last_s           = s_last[grant_idx];
            mux_keep_s           = s_keep[grant_idx];
            mux_data_s           = s_data[grant_idx];
            s_ready[grant_idx]   = mux_ready_s;
        end else begin
            s_ready = '0;
        end
    end

    // Grant is held from the first beat until the last beat is accepted on the mux side.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r   <= IDLE;
            ptr_r     <= IDX_W'(N_IN - 1);
            grant_idx <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (|s_valid) begin
                        grant_idx <= next_idx_s;
                        ptr_r     <= next_idx_s;
                        state_r   <= BUSY;
                    end
                end
                BUSY: begin
                    if (fire_s && mux_last_s) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

`ifdef AXIS_PACKET_ARBITER_OUT_REG_EN
    localparam int PAY_W = 1 + WORDS_PER_BEAT + WORDS_PER_BEAT * WORD_W;
    logic [PAY_W-1:0] out_pay_s;

    axis_skid_buf #(.W(PAY_W)) u_skid (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (mux_valid_s),
        .in_ready  (mux_ready_s),
        .in_data   ({mux_last_s, mux_keep_s, mux_data_s}),
        .out_valid (m_valid),
        .out_ready (m_ready),
        .out_data  (out_pay_s)
    );

    assign {m_last, m_keep, m_data} = out_pay_s;
`else
    assign mux_ready_s = m_ready;
    assign m_valid     = mux_valid_s;
    assign m_last      = mux_last_s;
    assign m_keep      = mux_keep_s;
    assign m_data      = mux_data_s;
`endif

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Self-checking bench for axis_packet_arbiter: per-source scoreboard plus grant-order tables.
module tb_axis_packet_arbiter;

    localparam int N = 4;
`ifdef AXIS_PACKET_ARBITER_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    typedef struct packed {
        logic        last;
        logic [3:0]  keep;
        logic [31:0] data;
    } beat_t;

    typedef struct packed {
        logic [3:0]      req;
        logic [2:0]      n;
        logic [3:0][1:0] order;
    } vec_t;

    logic                   clk = 1'b0;
    logic                   rstn = 1'b0;
    logic [N-1:0]           s_valid, s_ready, s_last;
    logic [N-1:0][3:0]      s_keep;
    logic [N-1:0][3:0][7:0] s_data;
    logic                   m_valid, m_ready, m_last;
    logic [3:0]             m_keep;
    logic [3:0][7:0]        m_data;
    logic [1:0]             grant_idx;
    logic                   busy;

    beat_t  stim_q[N][$];
    beat_t  exp_q[N][$];
    int     src_q[$];
    int     grant_idx_log[$];
    int     grant_cyc_log[$];
    int     out_cyc_log[$];
    int     last_cyc[N];
    int     acc_cnt[N];
    int     fall_cyc;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     beats_in = 0;
    int     beats_out = 0;
    logic   busy_prev = 1'b0;
    logic   rand_ready = 1'b0;
    logic [N-1:0] acc_v;
    vec_t   tbl[8];

    axis_packet_arbiter #(.N_IN(4), .WORD_W(8), .BUS_W(32)) dut (
        .clk(clk), .rstn(rstn),
        .s_valid(s_valid), .s_ready(s_ready), .s_last(s_last), .s_keep(s_keep), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last), .m_keep(m_keep), .m_data(m_data),
        .grant_idx(grant_idx), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic push_beat(input int port, input beat_t b);
        stim_q[port].push_back(b);
        exp_q[port].push_back(b);
    endtask

    task automatic send_pkt(input int port, input int len, input logic [3:0] last_keep);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.data = $urandom;
            b.last = (k == len - 1);
            b.keep = (k == len - 1) ? last_keep : 4'b1111;
            push_beat(port, b);
        end
    endtask

    function automatic bit idle_all();
        bit r;
        r = !busy && !m_valid && (src_q.size() == 0);
        for (int i = 0; i < N; i++) begin
            if (stim_q[i].size() != 0 || exp_q[i].size() != 0) r = 1'b0;
        end
        return r;
    endfunction

    // One clock: observe at negedge, then drive new inputs just after posedge.
    task automatic tick();
        beat_t b, e;
        int src;
        logic [N-1:0] allowed;
        @(negedge clk);
        acc_v   = s_valid & s_ready;
        allowed = busy ? (4'b0001 << grant_idx) : 4'b0000;
        chk("s_ready_legal", 64'(s_ready & ~allowed), 64'd0);
`ifndef AXIS_PACKET_ARBITER_OUT_REG_EN
        if (busy) chk("s_ready_follows_m_ready", 64'(s_ready[grant_idx]), 64'(m_ready));
        else      chk("m_valid_idle", 64'(m_valid), 64'd0);
`endif
        for (int i = 0; i < N; i++) begin
            if (acc_v[i]) begin
                src_q.push_back(i);
                acc_cnt[i]++;
                beats_in++;
                if (s_last[i]) last_cyc[i] = cyc;
            end
        end
        if (m_valid && m_ready) begin
            beats_out++;
            out_cyc_log.push_back(cyc);
            b = {m_last, m_keep, m_data};
            if (src_q.size() == 0) begin
                chk("output_without_input", 64'd1, 64'd0);
            end else begin
                src = src_q.pop_front();
`ifndef AXIS_PACKET_ARBITER_OUT_REG_EN
                chk("out_source", 64'(grant_idx), 64'(src));
`endif
                if (exp_q[src].size() == 0) begin
                    chk($sformatf("extra_beat_p%0d", src), 64'd1, 64'd0);
                end else begin
                    e = exp_q[src].pop_front();
                    chk($sformatf("beat_p%0d", src), 64'(b), 64'(e));
                end
            end
        end
        if (busy && !busy_prev) begin
            grant_idx_log.push_back(int'(grant_idx));
            grant_cyc_log.push_back(cyc);
        end
        if (!busy && busy_prev) fall_cyc = cyc;
        busy_prev = busy;
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < N; i++) begin
            if (acc_v[i] && stim_q[i].size() > 0) stim_q[i].delete(0);
            if (stim_q[i].size() > 0) begin
                b          = stim_q[i][0];
                s_valid[i] = 1'b1;
                s_last[i]  = b.last;
                s_keep[i]  = b.keep;
                s_data[i]  = b.data;
            end else begin
                s_valid[i] = 1'b0;
                s_last[i]  = 1'b0;
                s_keep[i]  = 4'b0000;
                s_data[i]  = 32'h0;
            end
        end
        m_ready = rand_ready ? ($urandom_range(0, 4) == 0) : 1'b1;
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (!idle_all() && n < budget) begin
            tick();
            n++;
        end
        chk({name, "_drained"}, 64'(idle_all()), 64'd1);
        tick();
        tick();
    endtask

    task automatic clear_logs();
        grant_idx_log.delete();
        grant_cyc_log.delete();
        out_cyc_log.delete();
        for (int i = 0; i < N; i++) acc_cnt[i] = 0;
    endtask

    initial begin
        int v, n;
        logic [3:0] lk;
        beat_t b;
        // {requests, grant count, grant order (order[0] in the low bits)}, starting from reset
        tbl[0] = {4'b1001, 3'd2, {2'd0, 2'd0, 2'd3, 2'd0}};
        tbl[1] = {4'b1111, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
        tbl[2] = {4'b0101, 3'd2, {2'd0, 2'd0, 2'd2, 2'd0}};
        tbl[3] = {4'b1001, 3'd2, {2'd0, 2'd0, 2'd0, 2'd3}};
        tbl[4] = {4'b0001, 3'd1, {2'd0, 2'd0, 2'd0, 2'd0}};
        tbl[5] = {4'b0110, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};
        tbl[6] = {4'b1011, 3'd3, {2'd0, 2'd1, 2'd0, 2'd3}};
        tbl[7] = {4'b0011, 3'd2, {2'd0, 2'd0, 2'd1, 2'd0}};

        s_valid = '0; s_last = '0; s_keep = '0; s_data = '0; m_ready = 1'b1;
        for (int i = 0; i < N; i++) begin last_cyc[i] = 0; acc_cnt[i] = 0; end
        fall_cyc = 0;

        // Reset state
        tick();
        tick();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_keep", 64'(m_keep), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_s_ready", 64'(s_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_grant_idx", 64'(grant_idx), 64'd0);
        rstn = 1'b1;
        tick();

        // Grant order tables, one-beat packets, m_ready held high
        for (int t = 0; t < 8; t++) begin
            clear_logs();
            for (int p = 0; p < N; p++) begin
                if (tbl[t].req[p]) send_pkt(p, 1, 4'b1111);
            end
            drain($sformatf("table%0d", t), 200);
            chk($sformatf("table%0d_ngrants", t), 64'(grant_idx_log.size()), 64'(tbl[t].n));
            for (int k = 0; k < int'(tbl[t].n) && k < grant_idx_log.size(); k++) begin
                chk($sformatf("table%0d_grant%0d", t, k), 64'(grant_idx_log[k]), 64'(tbl[t].order[k]));
                if (k > 0) chk($sformatf("table%0d_gap%0d", t, k),
                               64'(grant_cyc_log[k] - grant_cyc_log[k-1]), 64'd2);
            end
        end

        // Single 3-beat packet on port 0
        clear_logs();
        b = {1'b0, 4'b1111, 32'h11223344}; push_beat(0, b);
        b = {1'b0, 4'b1111, 32'h55667788}; push_beat(0, b);
        b = {1'b1, 4'b1111, 32'h99AABBCC}; push_beat(0, b);
        tick();
        v = cyc;
        drain("single", 100);
        chk("single_ngrants", 64'(grant_idx_log.size()), 64'd1);
        if (grant_idx_log.size() == 1) begin
            chk("single_grant_idx", 64'(grant_idx_log[0]), 64'd0);
            chk("single_grant_cycle", 64'(grant_cyc_log[0] - v), 64'd1);
        end
        chk("single_busy_fall", 64'(fall_cyc - last_cyc[0]), 64'd1);
        chk("single_nbeats", 64'(out_cyc_log.size()), 64'd3);
        for (int k = 0; k < out_cyc_log.size() && k < 3; k++) begin
            chk($sformatf("single_out_cycle%0d", k), 64'(out_cyc_log[k] - v), 64'(1 + LAT + k));
        end

        // No interleave: port 2 arrives while port 1 is mid-packet
        clear_logs();
        send_pkt(1, 4, 4'b1111);
        n = 0;
        while (acc_cnt[1] < 1 && n < 50) begin tick(); n++; end
        chk("ni_reached_beat2", 64'(acc_cnt[1]), 64'd1);
        send_pkt(2, 2, 4'b0011);
        drain("ni", 200);
        chk("ni_ngrants", 64'(grant_idx_log.size()), 64'd2);
        if (grant_idx_log.size() == 2) begin
            chk("ni_first", 64'(grant_idx_log[0]), 64'd1);
            chk("ni_second", 64'(grant_idx_log[1]), 64'd2);
            chk("ni_gap", 64'(grant_cyc_log[1] - last_cyc[1]), 64'd2);
        end

        // Backpressure: 50 random packets, m_ready high 20% of cycles
        clear_logs();
        beats_in = 0;
        beats_out = 0;
        for (int p = 0; p < 50; p++) begin
            case ($urandom_range(0, 3))
                0:       lk = 4'b1111;
                1:       lk = 4'b0111;
                2:       lk = 4'b0001;
                default: lk = 4'b0011;
            endcase
            if (p % 4 == 0) lk = 4'b0011;
            send_pkt($urandom_range(0, 3), $urandom_range(1, 16), lk);
        end
        rand_ready = 1'b1;
        drain("bp", 30000);
        rand_ready = 1'b0;
        chk("bp_beat_count", 64'(beats_out), 64'(beats_in));

        // Reset during beat 2 of a 5-beat packet on port 3
        clear_logs();
        send_pkt(3, 5, 4'b1111);
        n = 0;
        while (acc_cnt[3] < 1 && n < 50) begin tick(); n++; end
        chk("rm_reached_beat2", 64'(acc_cnt[3]), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("rm_m_valid", 64'(m_valid), 64'd0);
        chk("rm_s_ready", 64'(s_ready), 64'd0);
        chk("rm_busy", 64'(busy), 64'd0);
        chk("rm_grant_idx", 64'(grant_idx), 64'd0);
        stim_q[3].delete();
        exp_q[3].delete();
        src_q.delete();
        tick();
        tick();
        rstn = 1'b1;
        clear_logs();
        send_pkt(0, 1, 4'b1111);
        send_pkt(3, 2, 4'b1111);
        drain("rm", 200);
        chk("rm_ngrants", 64'(grant_idx_log.size()), 64'd2);
        if (grant_idx_log.size() == 2) begin
            chk("rm_first_port0", 64'(grant_idx_log[0]), 64'd0);
            chk("rm_second_port3", 64'(grant_idx_log[1]), 64'd3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
